// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch stage (read-only) and the load/store stage.
// Optional starvation guard for fetch is built when MEM_ARB_FAIRNESS_EN is defined.
module mem_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  // Elaboration-time guard on parameter ranges
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("mem_arbiter: RD_LAT out of range 1..4");
  end
  if (STREAK_MAX < 1 || STREAK_MAX > 15) begin : g_bad_streak_max
    $error("mem_arbiter: STREAK_MAX out of range 1..15");
  end

  state_t     state, state_nxt;
  logic       owner, owner_nxt;
  logic [1:0] lat_cnt, lat_cnt_nxt;
  logic       wr_q, wr_q_nxt;
  logic       window;
  logic       resp;
  logic       fetch_turn;
  logic       grant_if;
  logic       grant_d;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

  logic [3:0] streak, streak_nxt;

  // Fetch wins when data is idle, or once data has hogged STREAK_MAX windows in a row
  always_comb begin
    fetch_turn = if_req && (!d_req || (streak == STREAK_LIM));
  end

  // Streak counts data grants made while fetch is waiting
  always_comb begin
    streak_nxt = streak;
    if (!if_req) begin
      streak_nxt = 4'd0;
    end else if (grant_if) begin
      streak_nxt = 4'd0;
    end else if (grant_d && (streak != 4'hF)) begin
      streak_nxt = streak + 4'd1;
    end else begin
      streak_nxt = streak;
    end
  end

  // Streak register
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= 4'd0;
    end else begin
      streak <= streak_nxt;
    end
  end
`else
  // Strict data priority: fetch only wins an uncontested window
  always_comb begin
    fetch_turn = if_req && !d_req;
  end
`endif

  // Grant window and winner selection; grants are suppressed while reset is applied
  always_comb begin
    window   = (state == IDLE) || (lat_cnt == 2'd0);
    resp     = (state == BUSY) && (lat_cnt == 2'd0) && !rst;
    grant_if = window && fetch_turn && !rst;
    grant_d  = window && d_req && !fetch_turn && !rst;
  end

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    lat_cnt_nxt = lat_cnt;
    wr_q_nxt    = wr_q;
    case (state)
      IDLE, BUSY: begin
        if (grant_if || grant_d) begin
          state_nxt   = BUSY;
          lat_cnt_nxt = LAT_INIT;
          owner_nxt   = grant_d;
          wr_q_nxt    = grant_d && d_we;
        end else if (window) begin
          state_nxt   = IDLE;
          lat_cnt_nxt = 2'd0;
        end else begin
          lat_cnt_nxt = lat_cnt - 2'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        lat_cnt_nxt = 2'd0;
      end
    endcase
  end

  // State registers; reset drops any in-flight transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      lat_cnt <= 2'd0;
      wr_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      lat_cnt <= lat_cnt_nxt;
      wr_q    <= wr_q_nxt;
    end
  end

  // Memory-side strobe and fields come straight from the winner; all zero otherwise
  always_comb begin
    m_req   = grant_if || grant_d;
    m_we    = 1'b0;
    m_be    = 4'h0;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    if (grant_d) begin
      m_we    = d_we;
      m_be    = d_we ? d_be : 4'hF;
      m_addr  = d_addr;
      m_wdata = d_we ? d_wdata : 32'h0;
    end else if (grant_if) begin
      m_be    = 4'hF;
      m_addr  = if_addr;
    end else begin
      m_we    = 1'b0;
    end
  end

  // Requester-side grants and responses
  always_comb begin
    if_gnt    = grant_if;
    d_gnt     = grant_d;
    if_rvalid = resp && !owner;
    d_rvalid  = resp && owner;
    if_rdata  = 32'h0;
    d_rdata   = 32'h0;
    if (if_rvalid) begin
      if_rdata = m_rdata;
    end else if (d_rvalid && !wr_q) begin
      d_rdata  = m_rdata;
    end else begin
      d_rdata  = 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances with RD_LAT = 1, 2, 3 exercised in turn.
// Fairness expectations follow MEM_ARB_FAIRNESS_EN.
module tb_mem_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [N-1:0]       if_req, if_gnt, if_rvalid;
  logic [N-1:0][31:0] if_addr, if_rdata;
  logic [N-1:0]       d_req, d_we, d_gnt, d_rvalid;
  logic [N-1:0][3:0]  d_be;
  logic [N-1:0][31:0] d_addr, d_wdata, d_rdata;
  logic [N-1:0]       m_req, m_we;
  logic [N-1:0][3:0]  m_be;
  logic [N-1:0][31:0] m_addr, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          k;
    logic        is_d;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  // Memory contents: fixed instruction at 0x40, otherwise a pattern of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [31:0] pipe [4];

    // Memory model: read data appears g+1 cycles after the strobe
    always @(posedge clk) begin
      pipe[0] <= m_req[g] ? mem_word(m_addr[g]) : 32'hFFFF_FFFF;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign m_rdata[g] = pipe[g];

    mem_arbiter #(.RD_LAT(g + 1), .STREAK_MAX(4)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_be(d_be[g]), .d_addr(d_addr[g]),
      .d_wdata(d_wdata[g]), .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .m_req(m_req[g]), .m_we(m_we[g]), .m_be(m_be[g]), .m_addr(m_addr[g]),
      .m_wdata(m_wdata[g]), .m_rdata(m_rdata[g])
    );
  end

  // Monitor: pops expected responses on rvalid, pushes new ones on grant
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      chk("rvalid_excl", {31'h0, if_rvalid[k] & d_rvalid[k]}, 96'h0);
      if (if_rvalid[k] || d_rvalid[k]) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: inst %0d rvalid at cycle %0d, expected none", k, cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_inst", k, mon_e.k);
          chk("rsp_src", d_rvalid[k], mon_e.is_d);
          chk("rsp_data", d_rvalid[k] ? d_rdata[k] : if_rdata[k], mon_e.data);
          chk("rsp_cycle", cyc, mon_e.due);
        end
      end
      if (!if_rvalid[k]) chk("if_rdata_idle", if_rdata[k], 96'h0);
      if (!d_rvalid[k])  chk("d_rdata_idle", d_rdata[k], 96'h0);
      if (!m_req[k])     chk("m_idle_zero", {m_we[k], m_be[k], m_addr[k], m_wdata[k]}, 96'h0);
      if (d_gnt[k]) begin
        sbq.push_back('{k, 1'b1, d_we[k] ? 32'h0 : mem_word(d_addr[k]), cyc + k + 1});
        chk("gnt_excl", if_gnt[k], 96'h0);
        chk("d_gnt_req", d_req[k], 96'h1);
        chk("d_m_fields", {m_req[k], m_we[k], m_be[k], m_addr[k]},
            {1'b1, d_we[k], d_we[k] ? d_be[k] : 4'hF, d_addr[k]});
        if (d_we[k]) chk("d_m_wdata", m_wdata[k], d_wdata[k]);
      end else if (if_gnt[k]) begin
        sbq.push_back('{k, 1'b0, mem_word(if_addr[k]), cyc + k + 1});
        chk("if_gnt_req", if_req[k], 96'h1);
        chk("if_m_fields", {m_req[k], m_we[k], m_be[k], m_addr[k]}, {1'b1, 1'b0, 4'hF, if_addr[k]});
      end
    end
  end

  logic [9:0] pat;

  initial begin
    rst = 1'b1;
    if_req = '0; if_addr = '0; d_req = '0; d_we = '0; d_be = '0; d_addr = '0; d_wdata = '0;

    // Reset held for two cycles, then idle
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++)
        chk("rst_outputs", {if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], m_req[k], m_we[k]}, 96'h0);
      nxt();
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) chk("idle_m_req", m_req[k], 96'h0);
      nxt();
    end

    // Single fetch, RD_LAT=1
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    @(negedge clk);
    chk("fetch_gnt", if_gnt[0], 96'h1);
    chk("fetch_m_addr", m_addr[0], 96'h40);
    nxt(); if_req[0] = 1'b0;
    @(negedge clk);
    chk("fetch_rvalid", if_rvalid[0], 96'h1);
    chk("fetch_rdata", if_rdata[0], 96'h0050_0093);
    nxt(); nxt();

    // Collision, RD_LAT=2: data first, fetch at the response cycle
    if_req[1] = 1'b1; if_addr[1] = 32'h80;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h100;
    @(negedge clk);
    chk("col_c0_gnts", {d_gnt[1], if_gnt[1]}, 96'h2);
    nxt(); d_req[1] = 1'b0;
    @(negedge clk);
    chk("col_c1_quiet", {d_gnt[1], if_gnt[1], m_req[1]}, 96'h0);
    nxt();
    @(negedge clk);
    chk("col_c2_d_rvalid", d_rvalid[1], 96'h1);
    chk("col_c2_d_rdata", d_rdata[1], 96'h0100_FEFF);
    chk("col_c2_if_gnt", if_gnt[1], 96'h1);
    nxt(); if_req[1] = 1'b0;
    @(negedge clk);
    chk("col_c3_if_rvalid", if_rvalid[1], 96'h0);
    nxt();
    @(negedge clk);
    chk("col_c4_if_rvalid", if_rvalid[1], 96'h1);
    chk("col_c4_if_rdata", if_rdata[1], 96'h0080_FF7F);
    nxt(); nxt();

    // Store, RD_LAT=2
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_be[1] = 4'b0011; d_addr[1] = 32'h200; d_wdata[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("st_gnt", d_gnt[1], 96'h1);
    chk("st_m", {m_we[1], m_be[1], m_addr[1], m_wdata[1]}, {1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF});
    nxt(); d_req[1] = 1'b0; d_we[1] = 1'b0; d_be[1] = 4'h0;
    @(negedge clk);
    chk("st_c1_rvalid", d_rvalid[1], 96'h0);
    nxt();
    @(negedge clk);
    chk("st_c2_rvalid", d_rvalid[1], 96'h1);
    chk("st_c2_rdata", d_rdata[1], 96'h0);
    nxt(); nxt();

    // Back-to-back loads, RD_LAT=1: next grant coincides with previous response
    d_req[0] = 1'b1; d_addr[0] = 32'h1000;
    @(negedge clk);
    chk("b2b_c0", {d_gnt[0], d_rvalid[0]}, 96'h2);
    nxt(); d_addr[0] = 32'h1004;
    @(negedge clk);
    chk("b2b_c1", {d_gnt[0], d_rvalid[0]}, 96'h3);
    chk("b2b_c1_rdata", d_rdata[0], 96'h1000_EFFF);
    nxt(); d_addr[0] = 32'h1008;
    @(negedge clk);
    chk("b2b_c2", {d_gnt[0], d_rvalid[0]}, 96'h3);
    chk("b2b_c2_rdata", d_rdata[0], 96'h1004_EFFB);
    nxt(); d_req[0] = 1'b0;
    @(negedge clk);
    chk("b2b_c3", {d_gnt[0], d_rvalid[0]}, 96'h1);
    chk("b2b_c3_rdata", d_rdata[0], 96'h1008_EFF7);
    nxt(); nxt();

    // Both requesters held, RD_LAT=1
`ifdef MEM_ARB_FAIRNESS_EN
    pat = 10'b1111011110;
`else
    pat = 10'b1111111111;
`endif
    d_req[0] = 1'b1; d_addr[0] = 32'h10; if_req[0] = 1'b1; if_addr[0] = 32'h20;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("fair_d_gnt", d_gnt[0], {95'h0, pat[9-i]});
      chk("fair_if_gnt", if_gnt[0], {95'h0, !pat[9-i]});
      nxt();
    end
    d_req[0] = 1'b0; if_req[0] = 1'b0;
    nxt(); nxt();

    // Reset mid-transaction, RD_LAT=3
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h300;
    @(negedge clk);
    chk("rm_c0_gnt", d_gnt[2], 96'h1);
    nxt(); d_req[2] = 1'b0; rst = 1'b1; sbq.delete();
    @(negedge clk);
    chk("rm_c1_quiet", {d_gnt[2], d_rvalid[2], m_req[2]}, 96'h0);
    nxt(); rst = 1'b0; d_req[2] = 1'b1; d_addr[2] = 32'h304;
    @(negedge clk);
    chk("rm_c2_fresh_gnt", d_gnt[2], 96'h1);
    nxt(); d_req[2] = 1'b0;
    @(negedge clk);
    chk("rm_c3_no_stale", d_rvalid[2], 96'h0);
    nxt();
    @(negedge clk);
    chk("rm_c4_rvalid", d_rvalid[2], 96'h0);
    nxt();
    @(negedge clk);
    chk("rm_c5_rvalid", d_rvalid[2], 96'h1);
    chk("rm_c5_rdata", d_rdata[2], 96'h0304_FCFB);
    nxt();

    repeat (4) nxt();
    chk("sb_drained", sbq.size(), 96'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
